// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch sequencer.
// The FETCH_MISALIGN_CHECK_EN build option is handled in fetch_sequencer.sv.
package fetch_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned PC_STEP      = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    STALL   = 2'd2,
    DISCARD = 2'd3
  } fetch_state_t;

  // Word offset is sign-extended and scaled to bytes; the sum wraps modulo 2^XLEN.
  function automatic logic [XLEN_DEFAULT-1:0] branch_target(
    input logic        [XLEN_DEFAULT-1:0] pc_plus4,
    input logic signed [15:0]             imm
  );
    logic [XLEN_DEFAULT-1:0] offset;
    offset = {{(XLEN_DEFAULT-18){imm[15]}}, imm, 2'b00};
    return pc_plus4 + offset;
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/valid handshake between the fetch sequencer and imem.
interface fetch_sequencer_if #(
  parameter int unsigned XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_valid;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_valid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_valid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_sequencer_skid_buf.sv
// One-entry {instr, pc_plus4} holding register used while decode is stalled.
module fetch_skid_buf #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            unload,
  input  logic            clear,
  input  logic [XLEN-1:0] instr_in,
  input  logic [XLEN-1:0] pc_plus4_in,
  output logic            valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc_plus4
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;

  always_comb begin
    valid_d    = valid_q;
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d    = 1'b1;
      instr_d    = instr_in;
      pc_plus4_d = pc_plus4_in;
    end else if (unload) begin
      valid_d = 1'b0;
    end
  end

  // Only the occupancy flag needs reset; payload is qualified by it.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
    instr_q    <= instr_d;
    pc_plus4_q <= pc_plus4_d;
  end

  assign valid    = valid_q;
  assign instr    = instr_q;
  assign pc_plus4 = pc_plus4_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: PC stepping, imem handshake, IF/ID register with skid, branch flush.
// Build option FETCH_MISALIGN_CHECK_EN adds a sticky fetch_misaligned flag and fetch block.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [XLEN-1:0]           pc_in,
  output logic [XLEN-1:0]           next_pc,
  output logic                      branch,
  output logic                      zero,
  output logic [XLEN-1:0]           branch_address,
  fetch_sequencer_if.master         imem,
  input  logic                      ex_branch,
  input  logic                      ex_zero,
  input  logic [XLEN-1:0]           ex_pc_plus4,
  input  logic signed [15:0]        ex_imm,
  input  logic                      id_stall,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic                      fetch_misaligned,
`endif
  output logic                      ifid_valid,
  output logic [XLEN-1:0]           ifid_instr,
  output logic [XLEN-1:0]           ifid_pc_plus4
);

  fetch_state_t    state_q, state_d;
  logic            ifid_valid_q, ifid_valid_d;
  logic [XLEN-1:0] ifid_instr_q, ifid_instr_d;
  logic [XLEN-1:0] ifid_pc_plus4_q, ifid_pc_plus4_d;
  logic            branch_q, branch_d;
  logic            zero_q, zero_d;
  logic [XLEN-1:0] branch_address_q, branch_address_d;

  logic            taken;
  logic            fetch_block;
  logic            accept;
  logic            to_ifid;
  logic            to_skid;
  logic            unload;
  logic [XLEN-1:0] pc_plus4;

  logic            skid_valid;
  logic [XLEN-1:0] skid_instr;
  logic [XLEN-1:0] skid_pc_plus4;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic            misaligned_q, misaligned_d;
  logic            pc_misaligned;

  assign pc_misaligned = (state_q == FETCH) && (pc_in[1:0] != 2'b00);
  assign fetch_block   = misaligned_q | pc_misaligned;

  always_comb begin
    misaligned_d = misaligned_q;
    if (taken) begin
      misaligned_d = 1'b0;
    end else if (pc_misaligned) begin
      misaligned_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= misaligned_d;
    end
  end

  assign fetch_misaligned = misaligned_q;
`else
  assign fetch_block = 1'b0;
`endif

  assign taken    = branch_q & zero_q;
  assign pc_plus4 = pc_in + XLEN'(PC_STEP);

  // A beat is only taken in FETCH; a taken branch in the same cycle kills it.
  always_comb begin
    accept  = (state_q == FETCH) && !fetch_block && imem.imem_valid && !taken;
    to_ifid = accept && (!ifid_valid_q || !id_stall);
    to_skid = accept && ifid_valid_q && id_stall;
    unload  = (state_q == STALL) && !id_stall && !taken;
  end

  fetch_skid_buf #(
    .XLEN (XLEN)
  ) u_skid (
    .clk         (clk),
    .reset       (reset),
    .load        (to_skid),
    .unload      (unload),
    .clear       (taken),
    .instr_in    (imem.imem_rdata),
    .pc_plus4_in (pc_plus4),
    .valid       (skid_valid),
    .instr       (skid_instr),
    .pc_plus4    (skid_pc_plus4)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   if (to_skid) state_d = STALL;
      STALL:   if (!id_stall) state_d = FETCH;
      DISCARD: if (imem.imem_valid) state_d = FETCH;
      default: state_d = IDLE;
    endcase
    // An in-flight request that has not returned yet must be swallowed after a flush.
    if (taken) begin
      state_d = ((state_q == FETCH) && !imem.imem_valid) ? DISCARD : FETCH;
    end
  end

  always_comb begin
    ifid_valid_d    = ifid_valid_q;
    ifid_instr_d    = ifid_instr_q;
    ifid_pc_plus4_d = ifid_pc_plus4_q;
    if (taken) begin
      ifid_valid_d = 1'b0;
    end else if (to_ifid) begin
      ifid_valid_d    = 1'b1;
      ifid_instr_d    = imem.imem_rdata;
      ifid_pc_plus4_d = pc_plus4;
    end else if (unload && skid_valid) begin
      ifid_valid_d    = 1'b1;
      ifid_instr_d    = skid_instr;
      ifid_pc_plus4_d = skid_pc_plus4;
    end else if (!id_stall) begin
      ifid_valid_d = 1'b0;
    end
  end

  always_comb begin
    branch_d         = ex_branch;
    zero_d           = ex_zero;
    branch_address_d = XLEN'(branch_target(XLEN_DEFAULT'(ex_pc_plus4), ex_imm));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      ifid_valid_q     <= 1'b0;
      ifid_instr_q     <= '0;
      ifid_pc_plus4_q  <= '0;
      branch_q         <= 1'b0;
      zero_q           <= 1'b0;
      branch_address_q <= '0;
    end else begin
      state_q          <= state_d;
      ifid_valid_q     <= ifid_valid_d;
      ifid_instr_q     <= ifid_instr_d;
      ifid_pc_plus4_q  <= ifid_pc_plus4_d;
      branch_q         <= branch_d;
      zero_q           <= zero_d;
      branch_address_q <= branch_address_d;
    end
  end

  // Reset forces the PC-facing outputs so an outstanding fetch is abandoned at once.
  always_comb begin
    imem.imem_req  = !reset && (state_q == FETCH) && !fetch_block;
    imem.imem_addr = reset ? RESET_PC : pc_in;
    next_pc        = reset ? RESET_PC : (accept ? pc_plus4 : pc_in);
  end

  assign branch         = branch_q;
  assign zero           = zero_q;
  assign branch_address = branch_address_q;
  assign ifid_valid     = ifid_valid_q;
  assign ifid_instr     = ifid_instr_q;
  assign ifid_pc_plus4  = ifid_pc_plus4_q;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Drives the program counter's `next_pc`, `branch`, `zero` and `branch_address` inputs.
- Runs the instruction-memory request/valid handshake at the current PC.
- Owns the IF/ID pipeline register, plus a 1-entry skid buffer for decode stalls.
- Flushes fetched state when EX resolves a taken branch; sits between the PC register, instruction memory and the decode stage.

Parameters:
- XLEN, 32, address/instruction width
- RESET_PC, 32'h0000_0000, value presented on `imem_addr`/`next_pc` while `reset`=1

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- pc_in  in  XLEN  current PC value from the PC register
- next_pc  out  XLEN  sequential next PC fed to the PC register
- branch  out  1  branch qualifier to the PC (registered copy of ex_branch)
- zero  out  1  ALU-zero qualifier to the PC (registered copy of ex_zero)
- branch_address  out  XLEN  branch target to the PC
- imem_req  out  1  fetch request
- imem_addr  out  XLEN  fetch address
- imem_valid  in  1  fetch data valid
- imem_rdata  in  XLEN  fetched instruction
- ex_branch  in  1  EX-stage instruction is a branch
- ex_zero  in  1  EX-stage ALU zero flag
- ex_pc_plus4  in  XLEN  PC+4 of the EX-stage instruction
- ex_imm  in  16  branch offset in words, signed
- id_stall  in  1  decode cannot accept a new instruction
- ifid_valid  out  1  IF/ID register holds a live instruction
- ifid_instr  out  XLEN  IF/ID instruction
- ifid_pc_plus4  out  XLEN  IF/ID PC+4

Behaviour:
- Reset (sync, active-high):
  - state=IDLE; ifid_valid=0, ifid_instr=0, ifid_pc_plus4=0.
  - skid empty; imem_req=0; branch=0; zero=0; branch_address=0.
  - next_pc=RESET_PC.
- Reset mid-operation drops any outstanding fetch without waiting for imem_valid.
- Arithmetic:
  - taken = branch & zero (the registered values the PC also sees).
  - branch/zero/branch_address are registered each cycle from ex_branch/ex_zero/(ex_pc_plus4 + (sext(ex_imm)<<2)).
  - All additions are modulo 2^XLEN; wrap from 32'hFFFF_FFFC to 0 is legal.
- next_pc is combinational:
  - pc_in+4 in the cycle an instruction is accepted (into IF/ID or skid);
  - pc_in otherwise (PC holds).
- imem_addr=pc_in; imem_req is combinational from state.
- States:
  - IDLE: imem_req=0; next cycle -> FETCH.
  - FETCH: imem_req=1, held until imem_valid.
    - imem_valid & (!ifid_valid | !id_stall): IF/ID <= {rdata, pc_in+4}, ifid_valid=1; stay FETCH.
    - imem_valid & ifid_valid & id_stall: skid <= {rdata, pc_in+4}; -> STALL.
    - No imem_valid: hold.
  - STALL: imem_req=0, PC holds. When id_stall=0: IF/ID <= skid, skid empty; -> FETCH.
  - DISCARD: imem_req=0 (no new request). The next imem_valid beat is dropped; -> FETCH.
- Taken branch (taken=1 in cycle T) has priority over id_stall and over acceptance:
  - ifid_valid<=0 and skid cleared at the T edge; nothing accepted in T.
  - If state=FETCH and imem_valid=0 in T -> DISCARD; otherwise -> FETCH.
  - The PC loads branch_address at the same T edge, so the first post-branch fetch is at the target in T+1.
- Latency: instruction visible on ifid_* one cycle after its imem_valid beat.
- ifid_valid=0 while id_stall=1: the empty IF/ID accepts anyway, no skid use.

Optional Feature:
- Macro: FETCH_MISALIGN_CHECK_EN.
- Defined:
  - Adds output fetch_misaligned (1 bit, reset 0).
  - It is set registered when in FETCH with pc_in[1:0]!=0; imem_req is forced to 0 and the block stays in FETCH until a taken branch.
  - It is cleared by reset or by a taken branch.
- Undefined: port absent; pc_in[1:0] ignored; imem_addr passes pc_in unchanged.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum {IDLE, FETCH, STALL, DISCARD};
  - XLEN default;
  - localparam PC_STEP=4;
  - function branch_target(pc_plus4, imm).
- One natural sub-module: fetch_skid_buf (1-entry {instr, pc_plus4} buffer with load/unload/clear).

Test Plan:
- Reset held 2 cycles, released with pc_in=0 -> IDLE one cycle, then imem_req=1 with imem_addr=0; all ifid_* =0 during reset.
- Zero-wait memory, rdata=32'h2008_0005 at pc 0 -> next cycle ifid_valid=1, ifid_instr=32'h2008_0005, ifid_pc_plus4=4; next_pc=4 in the accept cycle.
- id_stall=1 with ifid_valid=1 and imem_valid at pc 8 -> skid holds pc_plus4=12, state STALL, imem_req=0; drop stall -> ifid_pc_plus4=12 next cycle, fetch at pc 12 resumes.
- ex_branch=1, ex_zero=1, ex_pc_plus4=16, ex_imm=16'h0004 -> branch_address=32; next cycle ifid_valid=0; next fetch at 32.
- ex_branch=1, ex_zero=0 -> no flush; sequential fetch continues at pc+4.
- Taken branch while imem_valid is low in FETCH -> DISCARD; the next imem_valid beat is not written to IF/ID, and the first accepted beat is from the target address.
